// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: time-multiplexes one 16-bit asynchronous SRAM among
// NUM_PORTS requesters.
//   Stage A: combinational arbitration producing a one-hot gnt.
//   Stage B: command register that drives the SRAM pins for exactly one cycle.
//   Stage C: read capture that pulses rvalid[port] two edges after acceptance.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins and no pointer exists. Without it, arbitration is round-robin.
//
// Handshake (req/gnt): a port raises req[p] and holds we/addr/wdata/be stable.
// The command transfers at the posedge where req[p] & gnt[p] is high. The port
// may change its fields or drop req only after that edge. Dropping req before
// the grant withdraws the request. gnt depends combinationally on req, so a
// requester must never derive req from gnt.
module sram_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 20
) (
  input  logic                    Clk,
  input  logic                    Reset_h,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*16-1:0] wdata,
  input  logic [NUM_PORTS*2-1:0]  be,
  output logic [NUM_PORTS-1:0]    gnt,
  output logic [NUM_PORTS-1:0]    rvalid,
  output logic [15:0]             rdata,
  output logic                    SRAM_CE_N,
  output logic                    SRAM_OE_N,
  output logic                    SRAM_WE_N,
  output logic                    SRAM_UB_N,
  output logic                    SRAM_LB_N,
  output logic [ADDR_W-1:0]       SRAM_ADDR,
  inout  wire  [15:0]             SRAM_DQ
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Command register (stage B)
  logic              cmd_valid_q, cmd_valid_d;
  logic [PORT_W-1:0] cmd_port_q,  cmd_port_d;
  logic              cmd_we_q,    cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
  logic [15:0]       cmd_wdata_q, cmd_wdata_d;
  logic [1:0]        cmd_be_q,    cmd_be_d;

  // Read capture (stage C)
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [15:0]          rdata_q,  rdata_d;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic [PORT_W-1:0] ptr_q, ptr_d;
`endif

  // Arbitration results
  logic [NUM_PORTS-1:0] eligible;
  logic [PORT_W-1:0]    win_port;
  logic                 win_found;
  logic                 xfer;
  logic                 write_in_flight;

  // A write sitting in the command register blocks reads for one slot so the
  // bus gets an idle cycle before the SRAM is asked to drive DQ.
  assign write_in_flight = cmd_valid_q & cmd_we_q;

  // Stage A: pick the winner among eligible requesters; gnt is masked in reset.
  always_comb begin
    int tmp;
    eligible  = req & ~({NUM_PORTS{write_in_flight}} & ~we);
    win_port  = '0;
    win_found = 1'b0;
    tmp       = 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_port  = PORT_W'(i);
      end
    end
`else
    for (int i = 0; i < NUM_PORTS; i++) begin
      tmp = int'(ptr_q) + i;
      if (tmp >= NUM_PORTS) tmp = tmp - NUM_PORTS;
      if (!win_found && eligible[PORT_W'(tmp)]) begin
        win_found = 1'b1;
        win_port  = PORT_W'(tmp);
      end
    end
`endif
    gnt = '0;
    if (win_found && !Reset_h) gnt[win_port] = 1'b1;
  end

  assign xfer = win_found & ~Reset_h;

  // Next state for the command register and round-robin pointer.
  always_comb begin
    cmd_valid_d = xfer;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    if (xfer) begin
      cmd_port_d  = win_port;
      cmd_we_d    = we[win_port];
      cmd_addr_d  = addr[int'(win_port)*ADDR_W +: ADDR_W];
      cmd_wdata_d = wdata[int'(win_port)*16 +: 16];
      cmd_be_d    = be[int'(win_port)*2 +: 2];
    end
`ifndef SRAM_ARB_FIXED_PRIO_EN
    ptr_d = ptr_q;
    if (xfer) begin
      if (win_port == PORT_W'(NUM_PORTS - 1)) ptr_d = '0;
      else                                    ptr_d = win_port + 1'b1;
    end
`endif
  end

  // Stage C next state: capture DQ at the end of a read slot.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (cmd_valid_q && !cmd_we_q) begin
      rvalid_d[cmd_port_q] = 1'b1;
      rdata_d              = SRAM_DQ;
    end
  end

  // State registers; reset clears every stage so pins fall back to idle at once.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      cmd_valid_q <= 1'b0;
      cmd_port_q  <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Pin decode from the command register: idle, read or write slot.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_ADDR = '0;
    if (cmd_valid_q) begin
      SRAM_CE_N = 1'b0;
      SRAM_ADDR = cmd_addr_q;
      if (cmd_we_q) begin
        SRAM_WE_N = 1'b0;
        SRAM_UB_N = ~cmd_be_q[1];
        SRAM_LB_N = ~cmd_be_q[0];
      end else begin
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
    end
  end

  // DQ is driven only during a write slot and released when WE_N rises.
  assign SRAM_DQ = write_in_flight ? cmd_wdata_q : 16'hzzzz;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
